// File: rtl/button_event_ctrl.sv
// Avalon-MM master for the button PIO: programs irq_mask, services irq by read+clear, queues edge words in a FWFT FIFO.
// Event reaches evt_valid 4 cycles after irq is seen in IDLE; consumer stalls via evt_ready, a full FIFO drops and flags overflow.
module button_event_ctrl #(
    parameter int              WIDTH        = 4,
    parameter int              DEPTH        = 4,
    parameter logic [WIDTH-1:0] MASK_DEFAULT = {WIDTH{1'b1}}
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             pio_irq,
    output logic [1:0]       pio_address,
    output logic             pio_chipselect,
    output logic             pio_write_n,
    output logic [31:0]      pio_writedata,
    input  logic [31:0]      pio_readdata,
    input  logic [WIDTH-1:0] cfg_mask,
    input  logic             cfg_mask_load,
    output logic             evt_valid,
    output logic [WIDTH-1:0] evt_data,
    input  logic             evt_ready,
    output logic             overflow,
    input  logic             overflow_clr,
    output logic             busy
);

    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    typedef enum logic [2:0] {
        S_INIT, S_CLR, S_IDLE, S_RD, S_RDW, S_CLRW, S_PUSH
    } state_t;

    state_t           state, state_nxt;
    logic             run;
    logic [WIDTH-1:0] mask_reg;
    logic [WIDTH-1:0] pend_mask;
    logic             pend_flag;
    logic [WIDTH-1:0] cap;
    logic [WIDTH-1:0] cap_now;
    logic             load_req;
    logic [WIDTH-1:0] load_val;

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr, rd_ptr;
    logic [AW:0]      count;
    logic             push, pop, full, push_ok;

    logic unused_readdata;
    assign unused_readdata = ^pio_readdata[31:WIDTH];

    assign cap_now  = pio_readdata[WIDTH-1:0] & mask_reg;
    // A load pulse arriving in the same cycle as IDLE is honoured immediately, ahead of irq.
    assign load_req = pend_flag | cfg_mask_load;
    assign load_val = cfg_mask_load ? cfg_mask : pend_mask;

    // run holds the bus quiet until the first clock after reset release.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state <= S_INIT;
            run   <= 1'b0;
        end else begin
            state <= state_nxt;
            run   <= 1'b1;
        end
    end

    always_comb begin
        state_nxt = state;
        if (!run) begin
            state_nxt = S_INIT;
        end else begin
            case (state)
                S_INIT:  state_nxt = S_CLR;
                S_CLR:   state_nxt = S_IDLE;
                S_IDLE: begin
                    if (load_req)     state_nxt = S_INIT;
                    else if (pio_irq) state_nxt = S_RD;
                end
                S_RD:    state_nxt = S_RDW;
                S_RDW:   state_nxt = (cap_now == '0) ? S_IDLE : S_CLRW;
                S_CLRW:  state_nxt = S_PUSH;
                S_PUSH:  state_nxt = S_IDLE;
                default: state_nxt = S_INIT;
            endcase
        end
    end

    always_comb begin
        pio_address    = 2'd0;
        pio_chipselect = 1'b0;
        pio_write_n    = 1'b1;
        pio_writedata  = '0;
        busy           = 1'b1;
        if (run) begin
            case (state)
                S_INIT: begin
                    pio_address              = 2'd2;
                    pio_chipselect           = 1'b1;
                    pio_write_n              = 1'b0;
                    pio_writedata[WIDTH-1:0] = mask_reg;
                end
                S_CLR, S_CLRW: begin
                    pio_address              = 2'd3;
                    pio_chipselect           = 1'b1;
                    pio_write_n              = 1'b0;
                    pio_writedata[WIDTH-1:0] = {WIDTH{1'b1}};
                end
                S_RD: begin
                    pio_address    = 2'd3;
                    pio_chipselect = 1'b1;
                end
                S_IDLE:  busy = 1'b0;
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            mask_reg  <= MASK_DEFAULT;
            pend_mask <= '0;
            pend_flag <= 1'b0;
            cap       <= '0;
        end else begin
            if (run && state == S_IDLE && load_req) begin
                mask_reg  <= load_val;
                pend_flag <= 1'b0;
            end else if (cfg_mask_load) begin
                pend_mask <= cfg_mask;
                pend_flag <= 1'b1;
            end
            if (state == S_RDW) cap <= cap_now;
        end
    end

    // Enqueue commits on the CLRW->PUSH edge so the entry is visible during PUSH.
    assign push    = (state == S_CLRW);
    assign full    = (count == (AW+1)'(DEPTH));
    assign pop     = evt_valid & evt_ready;
    assign push_ok = push & (~full | pop);

    always_ff @(posedge clk) begin
        if (push_ok) mem[wr_ptr] <= cap;
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            count    <= '0;
            overflow <= 1'b0;
        end else begin
            if (push_ok) wr_ptr <= wr_ptr + 1'b1;
            if (pop)     rd_ptr <= rd_ptr + 1'b1;
            case ({push_ok, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: ;
            endcase
            if (push && full && !pop) overflow <= 1'b1;
            else if (overflow_clr)    overflow <= 1'b0;
        end
    end

    assign evt_valid = (count != '0);
    assign evt_data  = evt_valid ? mem[rd_ptr] : '0;

endmodule

// File: tb/tb_button_event_ctrl.sv
// Bench for button_event_ctrl with a behavioural PIO slave and a bus-transaction log.
module tb_button_event_ctrl;

    logic        clk = 1'b0;
    logic        reset_n;
    logic        pio_irq;
    logic [1:0]  pio_address;
    logic        pio_chipselect;
    logic        pio_write_n;
    logic [31:0] pio_writedata;
    logic [31:0] pio_readdata;
    logic [3:0]  cfg_mask;
    logic        cfg_mask_load;
    logic        evt_valid;
    logic [3:0]  evt_data;
    logic        evt_ready;
    logic        overflow;
    logic        overflow_clr;
    logic        busy;

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    button_event_ctrl #(.WIDTH(4), .DEPTH(4), .MASK_DEFAULT(4'hF)) dut (
        .clk(clk), .reset_n(reset_n), .pio_irq(pio_irq),
        .pio_address(pio_address), .pio_chipselect(pio_chipselect),
        .pio_write_n(pio_write_n), .pio_writedata(pio_writedata),
        .pio_readdata(pio_readdata), .cfg_mask(cfg_mask),
        .cfg_mask_load(cfg_mask_load), .evt_valid(evt_valid),
        .evt_data(evt_data), .evt_ready(evt_ready), .overflow(overflow),
        .overflow_clr(overflow_clr), .busy(busy)
    );

    // PIO slave: irq_mask at 2, edge_capture at 3 (any write clears), registered readdata.
    logic [3:0] s_mask, s_cap, inj;
    logic       force_irq;
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            s_mask       <= 4'h0;
            s_cap        <= 4'h0;
            pio_readdata <= 32'h0;
        end else begin
            if (pio_chipselect && !pio_write_n && pio_address == 2'd2) s_mask <= pio_writedata[3:0];
            if (pio_chipselect && !pio_write_n && pio_address == 2'd3) s_cap <= inj;
            else                                                       s_cap <= s_cap | inj;
            if (pio_chipselect && pio_write_n)
                pio_readdata <= (pio_address == 2'd3) ? {28'h0, s_cap} :
                                (pio_address == 2'd2) ? {28'h0, s_mask} : 32'h0;
        end
    end
    assign pio_irq = (|(s_cap & s_mask)) | force_irq;

    typedef struct packed {
        logic [1:0]  addr;
        logic        wr;
        logic [31:0] data;
    } xact_t;
    xact_t log_q[$];

    always @(negedge clk) begin
        if (pio_chipselect === 1'b1)
            log_q.push_back('{addr: pio_address, wr: ~pio_write_n, data: pio_writedata});
    end

    typedef struct {
        logic [3:0] inj;
        logic       pop;
        logic       clr;
        logic       exp_vld;
        logic [3:0] exp_dat;
        logic       exp_ovf;
    } vec_t;
    vec_t vecs[10];

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    task automatic chk_log(input string nm, input int idx, input logic [1:0] a,
                           input logic wr, input logic chk_data, input logic [31:0] d);
        if (idx >= log_q.size()) begin
            chk({nm, "_present"}, 32'h0, 32'h1);
        end else begin
            chk({nm, "_addr"}, 32'(log_q[idx].addr), 32'(a));
            chk({nm, "_wr"}, 32'(log_q[idx].wr), 32'(wr));
            if (chk_data) chk({nm, "_data"}, log_q[idx].data, d);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Inject one capture word and wait out the full service.
    task automatic service(input logic [3:0] v);
        inj = v;
        tick();
        inj = 4'h0;
        repeat (7) tick();
    endtask

    task automatic pop_one();
        evt_ready = 1'b1;
        tick();
        evt_ready = 1'b0;
    endtask

    int base;

    initial begin
        vecs[0] = '{4'h1, 1'b0, 1'b0, 1'b1, 4'h1, 1'b0};
        vecs[1] = '{4'h2, 1'b0, 1'b0, 1'b1, 4'h1, 1'b0};
        vecs[2] = '{4'h4, 1'b0, 1'b0, 1'b1, 4'h1, 1'b0};
        vecs[3] = '{4'h8, 1'b0, 1'b0, 1'b1, 4'h1, 1'b0};
        vecs[4] = '{4'h3, 1'b0, 1'b0, 1'b1, 4'h1, 1'b1};
        vecs[5] = '{4'h0, 1'b0, 1'b1, 1'b1, 4'h1, 1'b0};
        vecs[6] = '{4'h0, 1'b1, 1'b0, 1'b1, 4'h2, 1'b0};
        vecs[7] = '{4'h0, 1'b1, 1'b0, 1'b1, 4'h4, 1'b0};
        vecs[8] = '{4'h0, 1'b1, 1'b0, 1'b1, 4'h8, 1'b0};
        vecs[9] = '{4'h0, 1'b1, 1'b0, 1'b0, 4'h0, 1'b0};

        reset_n = 1'b0; cfg_mask = 4'h0; cfg_mask_load = 1'b0;
        evt_ready = 1'b0; overflow_clr = 1'b0; inj = 4'h0; force_irq = 1'b0;
        repeat (3) tick();
        chk("rst_cs", 32'(pio_chipselect), 32'h0);
        chk("rst_wn", 32'(pio_write_n), 32'h1);
        chk("rst_addr", 32'(pio_address), 32'h0);
        chk("rst_wdata", pio_writedata, 32'h0);
        chk("rst_vld", 32'(evt_valid), 32'h0);
        chk("rst_dat", 32'(evt_data), 32'h0);
        chk("rst_ovf", 32'(overflow), 32'h0);
        chk("rst_busy", 32'(busy), 32'h1);

        reset_n = 1'b1;
        tick();
        chk("init_cs", 32'(pio_chipselect), 32'h1);
        chk("init_wn", 32'(pio_write_n), 32'h0);
        chk("init_addr", 32'(pio_address), 32'h2);
        chk("init_data", pio_writedata, 32'h0000000F);
        tick();
        chk("clr_wr", 32'({pio_chipselect, pio_write_n}), 32'h2);
        chk("clr_addr", 32'(pio_address), 32'h3);
        tick();
        chk("idle_busy", 32'(busy), 32'h0);
        chk("idle_vld", 32'(evt_valid), 32'h0);
        chk("idle_cs", 32'(pio_chipselect), 32'h0);

        // Latency of one service, irq seen in IDLE at T.
        inj = 4'h5;
        tick();
        inj = 4'h0;
        tick();
        chk("t1_rd", 32'({pio_chipselect, pio_write_n, pio_address}), 32'hF);
        chk("t1_busy", 32'(busy), 32'h1);
        tick();
        chk("t2_idlebus", 32'(pio_chipselect), 32'h0);
        tick();
        chk("t3_clrw", 32'({pio_chipselect, pio_write_n, pio_address}), 32'hB);
        tick();
        chk("t4_vld", 32'(evt_valid), 32'h1);
        chk("t4_dat", 32'(evt_data), 32'h5);
        pop_one();
        chk("pop_vld", 32'(evt_valid), 32'h0);
        repeat (3) tick();

        // Fill, overflow, clear, drain.
        for (int i = 0; i < 10; i++) begin
            if (vecs[i].inj != 4'h0) service(vecs[i].inj);
            if (vecs[i].pop) pop_one();
            if (vecs[i].clr) begin
                overflow_clr = 1'b1;
                tick();
                overflow_clr = 1'b0;
            end
            chk($sformatf("vec%0d_vld", i), 32'(evt_valid), 32'(vecs[i].exp_vld));
            chk($sformatf("vec%0d_dat", i), 32'(evt_data), 32'(vecs[i].exp_dat));
            chk($sformatf("vec%0d_ovf", i), 32'(overflow), 32'(vecs[i].exp_ovf));
        end

        // Mask load during RDW is deferred until the service completes.
        base = log_q.size();
        inj = 4'h1;
        tick();
        inj = 4'h0;
        tick();
        tick();
        cfg_mask = 4'h3; cfg_mask_load = 1'b1;
        tick();
        cfg_mask_load = 1'b0;
        repeat (10) tick();
        chk("ml_count", 32'(log_q.size() - base), 32'd4);
        chk_log("ml_rd", base, 2'd3, 1'b0, 1'b0, 32'h0);
        chk_log("ml_clrw", base + 1, 2'd3, 1'b1, 1'b0, 32'h0);
        chk_log("ml_mask", base + 2, 2'd2, 1'b1, 1'b1, 32'h3);
        chk_log("ml_clr", base + 3, 2'd3, 1'b1, 1'b0, 32'h0);
        chk("ml_dat", 32'(evt_data), 32'h1);
        pop_one();

        // Capture outside the new mask: read happens, no clear, no push.
        base = log_q.size();
        inj = 4'hC;
        tick();
        inj = 4'h0; force_irq = 1'b1;
        tick();
        force_irq = 1'b0;
        repeat (8) tick();
        chk("sp_count", 32'(log_q.size() - base), 32'd1);
        chk_log("sp_rd", base, 2'd3, 1'b0, 1'b0, 32'h0);
        chk("sp_vld", 32'(evt_valid), 32'h0);

        // Load and irq together in IDLE: mask write goes first.
        base = log_q.size();
        inj = 4'h1;
        tick();
        inj = 4'h0; cfg_mask = 4'hF; cfg_mask_load = 1'b1;
        tick();
        cfg_mask_load = 1'b0;
        repeat (8) tick();
        chk("pri_count", 32'(log_q.size() - base), 32'd2);
        chk_log("pri_mask", base, 2'd2, 1'b1, 1'b1, 32'hF);
        chk_log("pri_clr", base + 1, 2'd3, 1'b1, 1'b0, 32'h0);

        // Reset asserted in CLRW with two entries queued.
        service(4'h1);
        service(4'h2);
        inj = 4'h4;
        tick();
        inj = 4'h0;
        repeat (3) tick();
        chk("rc_clrw", 32'({pio_chipselect, pio_write_n, pio_address}), 32'hB);
        chk("rc_head", 32'(evt_data), 32'h1);
        reset_n = 1'b0;
        #1;
        chk("rc_cs", 32'(pio_chipselect), 32'h0);
        chk("rc_wn", 32'(pio_write_n), 32'h1);
        chk("rc_vld", 32'(evt_valid), 32'h0);
        chk("rc_busy", 32'(busy), 32'h1);
        repeat (2) tick();
        reset_n = 1'b1;
        tick();
        chk("rc_init", 32'({pio_chipselect, pio_write_n, pio_address}), 32'hA);
        chk("rc_init_data", pio_writedata, 32'h0000000F);
        chk("rc_init_vld", 32'(evt_valid), 32'h0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
